// File: rtl/rf_pkg.sv
// rf_pkg: register-file geometry shared by the bank arbiter, register file and operand collectors.
package rf_pkg;
  localparam int NUM_BANKS = 4;
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ADDR_W = 3;
  localparam int DATA_W = 256;
  localparam int OCID_W = 4;
  typedef logic [BANK_W-1:0] bank_t;
endpackage

// File: rtl/rf_rr_pick.sv
// rf_rr_pick: round-robin selector, first set request at or after ptr scanning upward modulo N.
// Ports: req (request vector), ptr (scan start), gnt (one-hot winner, zero if no request), idx (winner index).
module rf_rr_pick #(
  parameter int N = 4,
  localparam int W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
    gnt = (|req) ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/rf_bank_arbiter.sv
// rf_bank_arbiter: per-bank scheduler granting one access per bank per cycle, writeback first with a read starvation guard.
// Ports: oc_req_* (collector read requests, slice i per collector) / oc_req_ready (combinational grant);
//        wb_* (writeback request) / wb_ready (combinational grant);
//        rf_addr/rf_wr/rf_wdata/rf_ocid (registered bank commands, one cycle after grant);
//        resp_valid/resp_ocid (read data owner, aligned with bank DataOut two cycles after grant).
module rf_bank_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_OC = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_OC-1:0]           oc_req_valid,
  input  logic [NUM_OC*BANK_W-1:0]    oc_req_bank,
  input  logic [NUM_OC*ADDR_W-1:0]    oc_req_addr,
  output logic [NUM_OC-1:0]           oc_req_ready,
  input  logic                        wb_valid,
  input  bank_t                       wb_bank,
  input  logic [ADDR_W-1:0]           wb_addr,
  input  logic [DATA_W-1:0]           wb_data,
  output logic                        wb_ready,
  output logic [NUM_BANKS*ADDR_W-1:0] rf_addr,
  output logic [NUM_BANKS-1:0]        rf_wr,
  output logic [NUM_BANKS*DATA_W-1:0] rf_wdata,
  output logic [NUM_BANKS*OCID_W-1:0] rf_ocid,
  output logic [NUM_BANKS-1:0]        resp_valid,
  output logic [NUM_BANKS*OCID_W-1:0] resp_ocid
);
  localparam int OC_W = NUM_OC > 1 ? $clog2(NUM_OC) : 1;
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [NUM_BANKS-1:0][NUM_OC-1:0] rreq, gnt;
  logic [NUM_BANKS-1:0][OC_W-1:0]   win, rr_ptr;
  logic [NUM_BANKS-1:0][SC_W-1:0]   starve_cnt;
  logic [NUM_BANKS-1:0]             pend, wwin, rwin, rd1;
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar i = 0; i < NUM_OC; i++) begin : g_oc
      assign rreq[b][i] = oc_req_valid[i] && oc_req_bank[i*BANK_W +: BANK_W] == BANK_W'(b);
    end
    assign pend[b] = |rreq[b];
    rf_rr_pick #(.N(NUM_OC)) u_pick (
      .req(rreq[b]),
      .ptr(rr_ptr[b]),
      .gnt(gnt[b]),
      .idx(win[b])
    );
    // A saturated starvation counter hands the bank to the pending read for one cycle.
    assign wwin[b] = !rst && wb_valid && wb_bank == BANK_W'(b) &&
                     !(pend[b] && starve_cnt[b] == SC_W'(STARVE_LIMIT));
    assign rwin[b] = !rst && pend[b] && !wwin[b];
  end
  always_comb begin
    oc_req_ready = '0;
    for (int b = 0; b < NUM_BANKS; b++) oc_req_ready |= rwin[b] ? gnt[b] : '0;
  end
  assign wb_ready = |wwin;
  // rd1 tracks which stage-1 commands are reads, so only reads reach the response stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_addr    <= '0;
      rf_wr      <= '0;
      rf_wdata   <= '0;
      rf_ocid    <= '0;
      resp_valid <= '0;
      resp_ocid  <= '0;
      rd1        <= '0;
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        rf_wr[b]      <= wwin[b];
        rd1[b]        <= rwin[b];
        resp_valid[b] <= rd1[b];
        if (rd1[b]) resp_ocid[b*OCID_W +: OCID_W] <= rf_ocid[b*OCID_W +: OCID_W];
        if (wwin[b]) begin
          rf_addr[b*ADDR_W +: ADDR_W]  <= wb_addr;
          rf_wdata[b*DATA_W +: DATA_W] <= wb_data;
        end else if (rwin[b]) begin
          rf_addr[b*ADDR_W +: ADDR_W] <= oc_req_addr[win[b]*ADDR_W +: ADDR_W];
          rf_ocid[b*OCID_W +: OCID_W] <= OCID_W'(win[b]);
          rr_ptr[b]                   <= OC_W'((int'(win[b]) + 1) % NUM_OC);
        end
        starve_cnt[b] <= (rwin[b] || !pend[b]) ? '0 :
                         (starve_cnt[b] == SC_W'(STARVE_LIMIT)) ? starve_cnt[b] : starve_cnt[b] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rf_bank_arbiter.sv
// tb_rf_bank_arbiter: table-driven grant vectors, hand sequences for reset and RAW, response scoreboard.
module tb_rf_bank_arbiter;
  import rf_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0]    oc_req_valid, oc_req_ready, rf_wr, resp_valid;
  logic [7:0]    oc_req_bank;
  logic [11:0]   oc_req_addr, rf_addr;
  logic          wb_valid, wb_ready;
  bank_t         wb_bank;
  logic [2:0]    wb_addr;
  logic [255:0]  wb_data;
  logic [1023:0] rf_wdata;
  logic [15:0]   rf_ocid, resp_ocid;
  rf_bank_arbiter dut (
    .clk(clk), .rst(rst),
    .oc_req_valid(oc_req_valid), .oc_req_bank(oc_req_bank), .oc_req_addr(oc_req_addr),
    .oc_req_ready(oc_req_ready),
    .wb_valid(wb_valid), .wb_bank(wb_bank), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .rf_addr(rf_addr), .rf_wr(rf_wr), .rf_wdata(rf_wdata), .rf_ocid(rf_ocid),
    .resp_valid(resp_valid), .resp_ocid(resp_ocid)
  );
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_pass = 0;
  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask
  logic [255:0] mem [4][8];
  logic [255:0] rdata [4];
  always @(posedge clk)
    for (int b = 0; b < 4; b++) begin
      if (rf_wr[b]) mem[b][rf_addr[b*3 +: 3]] <= rf_wdata[b*256 +: 256];
      rdata[b] <= mem[b][rf_addr[b*3 +: 3]];
    end
  typedef struct {int due; int bank; int ocid; logic cd; logic [255:0] d;} exp_t;
  exp_t q[$];
  exp_t e;
  always @(negedge clk) begin
    for (int b = 0; b < 4; b++)
      if (resp_valid[b]) begin
        if (q.size() == 0 || q[0].due != cyc || q[0].bank != b) chk("resp_unexpected", 256'(1), 256'(0));
        else begin
          e = q.pop_front();
          chk("resp_ocid", 256'(resp_ocid[b*4 +: 4]), 256'(e.ocid));
          if (e.cd) chk("resp_data", rdata[b], e.d);
        end
      end
    while (q.size() > 0 && q[0].due <= cyc) begin
      chk("resp_missing", 256'(0), 256'(1));
      void'(q.pop_front());
    end
  end
  typedef struct {
    logic [3:0] ov; logic [7:0] ob; logic [11:0] oa;
    logic wv; logic [1:0] wbk; logic [2:0] wa;
    logic [3:0] er; logic ew;
  } vec_t;
  vec_t v[17];
  function automatic vec_t mk(logic [3:0] ov, logic [7:0] ob, logic [11:0] oa, logic wv,
                              logic [1:0] wbk, logic [2:0] wa, logic [3:0] er, logic ew);
    vec_t r;
    r.ov = ov; r.ob = ob; r.oa = oa; r.wv = wv; r.wbk = wbk; r.wa = wa; r.er = er; r.ew = ew;
    return r;
  endfunction
  function automatic logic [255:0] wd(int k);
    return {8{32'hD000_0000 + 32'(k)}};
  endfunction
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic apply(vec_t p, int k);
    oc_req_valid = p.ov; oc_req_bank = p.ob; oc_req_addr = p.oa;
    wb_valid = p.wv; wb_bank = p.wbk; wb_addr = p.wa; wb_data = wd(k);
  endtask
  task automatic push(vec_t p);
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 4; i++)
        if (p.er[i] && int'(p.ob[i*2 +: 2]) == b) q.push_back('{cyc + 2, b, i, 1'b0, 256'h0});
  endtask
  task automatic stage1(vec_t p, int k);
    int b;
    chk("rf_wr", 256'(rf_wr), 256'(p.ew ? 4'b0001 << p.wbk : 4'b0000));
    if (p.ew) begin
      chk("rf_addr_wr", 256'(rf_addr[p.wbk*3 +: 3]), 256'(p.wa));
      chk("rf_wdata", rf_wdata[p.wbk*256 +: 256], wd(k));
    end
    for (int i = 0; i < 4; i++)
      if (p.er[i]) begin
        b = int'(p.ob[i*2 +: 2]);
        chk("rf_ocid", 256'(rf_ocid[b*4 +: 4]), 256'(i));
        chk("rf_addr_rd", 256'(rf_addr[b*3 +: 3]), 256'(p.oa[i*3 +: 3]));
      end
  endtask
  initial begin
    v[0]  = mk(4'b0100, 8'h10, 12'h140, 1'b0, 2'd0, 3'd0, 4'b0100, 1'b0);
    v[1]  = mk(4'b0000, 8'h00, 12'h000, 1'b0, 2'd0, 3'd0, 4'b0000, 1'b0);
    v[2]  = mk(4'b1111, 8'h00, 12'h688, 1'b0, 2'd0, 3'd0, 4'b0001, 1'b0);
    v[3]  = mk(4'b1111, 8'h00, 12'h688, 1'b0, 2'd0, 3'd0, 4'b0010, 1'b0);
    v[4]  = mk(4'b1111, 8'h00, 12'h688, 1'b0, 2'd0, 3'd0, 4'b0100, 1'b0);
    v[5]  = mk(4'b1111, 8'h00, 12'h688, 1'b0, 2'd0, 3'd0, 4'b1000, 1'b0);
    v[6]  = mk(4'b1111, 8'h00, 12'h688, 1'b0, 2'd0, 3'd0, 4'b0001, 1'b0);
    for (int k = 7; k < 15; k++)
      v[k] = mk(4'b0010, 8'h08, 12'h038, 1'b1, 2'd2, 3'd1,
                (k == 10 || k == 14) ? 4'b0010 : 4'b0000, !(k == 10 || k == 14));
    v[15] = mk(4'b0111, 8'h24, 12'h111, 1'b1, 2'd3, 3'd6, 4'b0111, 1'b1);
    v[16] = mk(4'b0000, 8'h00, 12'h000, 1'b0, 2'd0, 3'd0, 4'b0000, 1'b0);
    rst = 1'b1;
    oc_req_valid = 4'b1111; oc_req_bank = 8'h00; oc_req_addr = 12'h688;
    wb_valid = 1'b1; wb_bank = 2'd3; wb_addr = 3'd6; wb_data = '1;
    repeat (3) begin
      next();
      #1;
      chk("rst_oc_ready", 256'(oc_req_ready), 256'(0));
      chk("rst_wb_ready", 256'(wb_ready), 256'(0));
      chk("rst_rf_wr", 256'(rf_wr), 256'(0));
      chk("rst_resp_valid", 256'(resp_valid), 256'(0));
    end
    chk("rst_rf_addr", 256'(rf_addr), 256'(0));
    chk("rst_rf_wdata_lo", rf_wdata[255:0], 256'(0));
    chk("rst_rf_wdata_hi", rf_wdata[1023:768], 256'(0));
    chk("rst_rf_ocid", 256'(rf_ocid), 256'(0));
    chk("rst_resp_ocid", 256'(resp_ocid), 256'(0));
    rst = 1'b0;
    #1;
    chk("release_oc_ready", 256'(oc_req_ready), 256'(4'b0001));
    chk("release_wb_ready", 256'(wb_ready), 256'(1));
    next();
    rst = 1'b1;
    #1;
    chk("release_rf_wr", 256'(rf_wr), 256'(4'b1000));
    chk("midrst_oc_ready", 256'(oc_req_ready), 256'(0));
    next();
    #1;
    chk("midrst_resp_valid", 256'(resp_valid), 256'(0));
    chk("midrst_rf_wr", 256'(rf_wr), 256'(0));
    rst = 1'b0;
    apply(v[16], 16);
    for (int k = 0; k < 17; k++) begin
      next();
      apply(v[k], k);
      #1;
      chk("oc_req_ready", 256'(oc_req_ready), 256'(v[k].er));
      chk("wb_ready", 256'(wb_ready), 256'(v[k].ew));
      push(v[k]);
      if (k > 0) stage1(v[k-1], k - 1);
    end
    next();
    #1;
    stage1(v[16], 16);
    wb_valid = 1'b1; wb_bank = 2'd0; wb_addr = 3'd3; wb_data = {32{8'hA5}};
    #1;
    chk("raw_wb_ready", 256'(wb_ready), 256'(1));
    next();
    wb_valid = 1'b0; oc_req_valid = 4'b0001; oc_req_bank = 8'h00; oc_req_addr = 12'h003;
    #1;
    chk("raw_oc_ready", 256'(oc_req_ready), 256'(4'b0001));
    q.push_back('{cyc + 2, 0, 0, 1'b1, {32{8'hA5}}});
    chk("raw_rf_wr", 256'(rf_wr), 256'(4'b0001));
    chk("raw_rf_addr_wr", 256'(rf_addr[2:0]), 256'(3));
    chk("raw_rf_wdata", rf_wdata[255:0], {32{8'hA5}});
    next();
    oc_req_valid = 4'b0000;
    #1;
    chk("raw_rd_rf_wr", 256'(rf_wr), 256'(0));
    chk("raw_rd_rf_addr", 256'(rf_addr[2:0]), 256'(3));
    chk("raw_rd_rf_ocid", 256'(rf_ocid[3:0]), 256'(0));
    next();
    next();
    wb_valid = 1'b1; wb_bank = 2'd0; wb_addr = 3'd2; wb_data = {32{8'h5A}};
    #1;
    chk("raw2_wb_ready", 256'(wb_ready), 256'(1));
    next();
    wb_valid = 1'b0; oc_req_valid = 4'b0001; oc_req_addr = 12'h002;
    #1;
    chk("raw2_oc_ready", 256'(oc_req_ready), 256'(4'b0001));
    next();
    rst = 1'b1;
    #1;
    chk("raw2_rst_oc_ready", 256'(oc_req_ready), 256'(0));
    next();
    #1;
    chk("raw2_rst_resp_valid", 256'(resp_valid), 256'(0));
    chk("raw2_rst_rf_wr", 256'(rf_wr), 256'(0));
    rst = 1'b0;
    oc_req_valid = 4'b0000;
    repeat (4) next();
    chk("scoreboard_empty", 256'(q.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
